program_loader: RTL

- Upstream feeder for the relay computer top level.
- Accepts a program image as a byte stream over a valid/ready handshake and assembles it into the MEM_BYTES-entry initial_memory array.
- Pulses the computer's memory-load request, waits for loadMemComplete, then holds the image stable while the computer runs.
- Reports done or timeout error to the bench or host.

---
 rtl/program_loader_if.sv | 23 ++
 rtl/program_loader.sv | 105 ++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// Byte-stream and computer memory-load link between a host and the program loader.
// master: host/computer side (drives bytes and the load acknowledge).
// slave:  loader side (drives byte_ready, loadMem and the assembled image).
interface program_loader_if #(
  parameter int MEM_BYTES = 15
);
  logic [7:0]                 byte_in;
  logic                       byte_valid;
  logic                       byte_ready;
  logic [MEM_BYTES-1:0][7:0]  initial_memory;
  logic                       loadMem;
  logic                       loadMemComplete;

  modport master (
    output byte_in, byte_valid, loadMemComplete,
    input  byte_ready, initial_memory, loadMem
  );

  modport slave (
    input  byte_in, byte_valid, loadMemComplete,
    output byte_ready, initial_memory, loadMem
  );
endinterface

// File: rtl/program_loader.sv
// Program loader: assembles a MEM_BYTES byte image from a valid/ready stream,
// requests a memory load from the computer, waits for the ack or a timeout,
// then holds the image stable and reports done / error.
// Ports: clock, reset (sync, active-high), start/abort controls, bus (slave
// modport: byte stream + image + loadMem handshake), byte_count and status flags.
module program_loader #(
  parameter int MEM_BYTES      = 15,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  program_loader_if.slave      bus,
  output logic [3:0]           byte_count,
  output logic                 busy,
  output logic                 load_done,
  output logic                 load_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [3:0]    FULL      = 4'(MEM_BYTES);
  localparam logic [3:0]    LAST_BYTE = 4'(MEM_BYTES - 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FILL, LOAD, DONE, ERROR} state_t;

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] timer;
  logic          xfer;

  // byte_ready is a register, so the handshake never depends on byte_valid combinationally.
  assign xfer = bus.byte_valid & bus.byte_ready;

  always_comb begin
    state_nx = state;
    case (state)
      FILL: begin
        if (abort)
          state_nx = IDLE;
        else if (xfer && byte_count == LAST_BYTE)
          state_nx = LOAD;
      end
      LOAD: begin
        // Ack is tested before the timeout so an ack on the last cycle still wins.
        if (abort)
          state_nx = IDLE;
        else if (bus.loadMemComplete)
          state_nx = DONE;
        else if (timer == LAST_WAIT)
          state_nx = ERROR;
      end
      default: begin
        if (start)
          state_nx = FILL;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      bus.initial_memory <= '0;
      byte_count         <= '0;
      timer              <= '0;
      bus.loadMem        <= 1'b0;
      bus.byte_ready     <= 1'b0;
      busy               <= 1'b0;
      load_done          <= 1'b0;
      load_error         <= 1'b0;
    end else begin
      state <= state_nx;

      // Status outputs are registered from the next state so they line up with it.
      bus.byte_ready <= (state_nx == FILL);
      bus.loadMem    <= (state_nx == LOAD);
      busy           <= (state_nx == FILL) || (state_nx == LOAD);
      load_done      <= (state_nx == DONE);
      load_error     <= (state_nx == ERROR);

      case (state)
        FILL: begin
          // A byte offered alongside abort still completes its handshake.
          if (xfer && byte_count < FULL) begin
            bus.initial_memory[byte_count] <= bus.byte_in;
            byte_count                     <= byte_count + 4'd1;
          end
        end
        LOAD: begin
          timer <= timer + TW'(1);
        end
        default: begin
          // IDLE/DONE/ERROR: image and count are only touched by a fresh start.
          if (start) begin
            bus.initial_memory <= '0;
            byte_count         <= '0;
            timer              <= '0;
          end
        end
      endcase
    end
  end

endmodule
